// File: rtl/int_ctrl_if.sv
// Signal bundle between int_ctrl and its CLINT, CSR register file and pipeline neighbours.
interface int_ctrl_if;
   logic        time_up_i;
   logic [31:0] msip_i;
   logic        inst_valid_i;
   logic [31:0] inst_addr_i;
   logic        ecall_i;
   logic        ebreak_i;
   logic        mret_i;
   logic [31:0] mstatus_i;
   logic [31:0] mie_i;
   logic [31:0] mtvec_i;
   logic [31:0] mepc_i;
   logic        hold_o;
   logic        csr_we_o;
   logic [11:0] csr_waddr_o;
   logic [31:0] csr_wdata_o;
   logic        int_assert_o;
   logic [31:0] int_addr_o;

   modport slave (
      input  time_up_i, msip_i, inst_valid_i, inst_addr_i, ecall_i, ebreak_i, mret_i,
      input  mstatus_i, mie_i, mtvec_i, mepc_i,
      output hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o
   );

   modport master (
      output time_up_i, msip_i, inst_valid_i, inst_addr_i, ecall_i, ebreak_i, mret_i,
      output mstatus_i, mie_i, mtvec_i, mepc_i,
      input  hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o
   );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt/trap sequencer: stalls the pipeline, writes mepc/mcause/mstatus one per
// cycle, then redirects fetch to mtvec; mret restores mstatus and redirects to mepc.
module int_ctrl #(
   parameter logic [11:0] CSR_MSTATUS = 12'h300,
   parameter logic [11:0] CSR_MEPC    = 12'h341,
   parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
   input  logic       clk,
   input  logic       rst,
   int_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      W_MEPC    = 3'd1,
      W_MCAUSE  = 3'd2,
      W_MSTATUS = 3'd3,
      JUMP      = 3'd4,
      R_MSTATUS = 3'd5,
      R_JUMP    = 3'd6
   } state_t;

   localparam logic [31:0] CAUSE_ECALL  = 32'd11;
   localparam logic [31:0] CAUSE_EBREAK = 32'd3;
   localparam logic [31:0] CAUSE_SOFT   = 32'h8000_0003;
   localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

   // Trap entry: MPIE takes the old MIE, MIE is cleared.
   function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
      logic [31:0] r;
      r    = ms;
      r[7] = ms[3];
      r[3] = 1'b0;
      return r;
   endfunction

   // Trap return: MIE takes MPIE, MPIE is set.
   function automatic logic [31:0] ret_mstatus(input logic [31:0] ms);
      logic [31:0] r;
      r    = ms;
      r[3] = ms[7];
      r[7] = 1'b1;
      return r;
   endfunction

   state_t      state_r;
   state_t      state_next_s;
   logic        guard_r;
   logic [31:0] cause_r;
   logic [31:0] epc_r;

   logic        sw_pend_s;
   logic        tm_pend_s;
   logic        detect_s;
   logic        trap_s;
   logic        mret_s;
   logic [31:0] cause_s;

   logic        csr_we_s;
   logic [11:0] csr_waddr_s;
   logic [31:0] csr_wdata_s;
   logic        int_assert_s;
   logic [31:0] int_addr_s;
   logic        unused_s;

   assign sw_pend_s = bus.mstatus_i[3] & bus.mie_i[3] & bus.msip_i[0];
   assign tm_pend_s = bus.mstatus_i[3] & bus.mie_i[7] & bus.time_up_i;
   assign detect_s  = (state_r == IDLE) & bus.inst_valid_i & ~guard_r;
   assign unused_s  = ^{bus.msip_i[31:1], bus.mie_i[31:8], bus.mie_i[6:4],
                        bus.mie_i[2:0], bus.mtvec_i[1:0]};

   // Priority selection of the event taken in the detection cycle
   always_comb begin
      trap_s  = 1'b0;
      mret_s  = 1'b0;
      cause_s = 32'd0;
      if (!detect_s) begin
         trap_s = 1'b0;
      end else if (bus.ecall_i) begin
         trap_s  = 1'b1;
         cause_s = CAUSE_ECALL;
      end else if (bus.ebreak_i) begin
         trap_s  = 1'b1;
         cause_s = CAUSE_EBREAK;
      end else if (bus.mret_i) begin
         mret_s = 1'b1;
      end else if (sw_pend_s) begin
         trap_s  = 1'b1;
         cause_s = CAUSE_SOFT;
      end else if (tm_pend_s) begin
         trap_s  = 1'b1;
         cause_s = CAUSE_TIMER;
      end else begin
         trap_s = 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (trap_s) begin
               state_next_s = W_MEPC;
            end else if (mret_s) begin
               state_next_s = R_MSTATUS;
            end else begin
               state_next_s = IDLE;
            end
         end
         W_MEPC:    state_next_s = W_MCAUSE;
         W_MCAUSE:  state_next_s = W_MSTATUS;
         W_MSTATUS: state_next_s = JUMP;
         JUMP:      state_next_s = IDLE;
         R_MSTATUS: state_next_s = R_JUMP;
         R_JUMP:    state_next_s = IDLE;
         default:   state_next_s = IDLE;
      endcase
   end

   // State, guard and latched trap context; guard covers the cycle after a redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         guard_r <= 1'b0;
         cause_r <= 32'd0;
         epc_r   <= 32'd0;
      end else begin
         state_r <= state_next_s;
         guard_r <= (state_r == JUMP) || (state_r == R_JUMP);
         if (trap_s) begin
            cause_r <= cause_s;
            epc_r   <= bus.inst_addr_i;
         end else begin
            cause_r <= cause_r;
            epc_r   <= epc_r;
         end
      end
   end

   // CSR write port and redirect decode from the registered state
   always_comb begin
      csr_we_s     = 1'b0;
      csr_waddr_s  = 12'd0;
      csr_wdata_s  = 32'd0;
      int_assert_s = 1'b0;
      int_addr_s   = 32'd0;
      case (state_r)
         W_MEPC: begin
            csr_we_s    = 1'b1;
            csr_waddr_s = CSR_MEPC;
            csr_wdata_s = epc_r;
         end
         W_MCAUSE: begin
            csr_we_s    = 1'b1;
            csr_waddr_s = CSR_MCAUSE;
            csr_wdata_s = cause_r;
         end
         W_MSTATUS: begin
            csr_we_s    = 1'b1;
            csr_waddr_s = CSR_MSTATUS;
            csr_wdata_s = trap_mstatus(bus.mstatus_i);
         end
         JUMP: begin
            int_assert_s = 1'b1;
            int_addr_s   = {bus.mtvec_i[31:2], 2'b00};
         end
         R_MSTATUS: begin
            csr_we_s    = 1'b1;
            csr_waddr_s = CSR_MSTATUS;
            csr_wdata_s = ret_mstatus(bus.mstatus_i);
         end
         R_JUMP: begin
            int_assert_s = 1'b1;
            int_addr_s   = bus.mepc_i;
         end
         default: begin
            csr_we_s = 1'b0;
         end
      endcase
   end

   assign bus.csr_we_o     = csr_we_s;
   assign bus.csr_waddr_o  = csr_waddr_s;
   assign bus.csr_wdata_o  = csr_wdata_s;
   assign bus.int_assert_o = int_assert_s;
   assign bus.int_addr_o   = int_addr_s;
   assign bus.hold_o       = ~rst & ((state_r != IDLE) | trap_s | mret_s);

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus randomized traffic, all checked against a
// schedule-based reference model of the trap/return sequences.
module tb_int_ctrl;
   logic clk = 1'b0;
   logic rst;

   int_ctrl_if bus ();
   int_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef enum int {K_MEPC, K_MCAUSE, K_MST_T, K_JMP_T, K_MST_R, K_JMP_R} kind_t;
   typedef struct {
      kind_t       kind;
      logic [31:0] val;
   } step_t;

   step_t sched[$];
   bit    guard_m;
   int    n_checks = 0;
   int    n_fail   = 0;

   logic        obs_hold, obs_we, obs_ia;
   logic [11:0] obs_waddr;
   logic [31:0] obs_wdata, obs_iaddr;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic push_step(input kind_t k, input logic [31:0] v);
      step_t s;
      s.kind = k;
      s.val  = v;
      sched.push_back(s);
   endtask

   // One clock: check outputs at negedge against the model, then step past the posedge.
   task automatic tick();
      logic        e_hold, e_we, e_ia, sw, tm;
      logic [11:0] e_waddr;
      logic [31:0] e_wdata, e_iaddr, ms;
      step_t       s;
      @(negedge clk);
      obs_hold  = bus.hold_o;
      obs_we    = bus.csr_we_o;
      obs_waddr = bus.csr_waddr_o;
      obs_wdata = bus.csr_wdata_o;
      obs_ia    = bus.int_assert_o;
      obs_iaddr = bus.int_addr_o;
      e_hold = 1'b0; e_we = 1'b0; e_ia = 1'b0;
      e_waddr = 12'd0; e_wdata = 32'd0; e_iaddr = 32'd0;
      ms = bus.mstatus_i;
      if (rst) begin
         check_eq("hold_in_reset", {31'd0, obs_hold}, 32'd0);
         sched.delete();
         guard_m = 1'b0;
      end else begin
         if (sched.size() != 0) begin
            s = sched.pop_front();
            e_hold = 1'b1;
            case (s.kind)
               K_MEPC:   begin e_we = 1'b1; e_waddr = 12'h341; e_wdata = s.val; end
               K_MCAUSE: begin e_we = 1'b1; e_waddr = 12'h342; e_wdata = s.val; end
               K_MST_T:  begin e_we = 1'b1; e_waddr = 12'h300;
                               e_wdata = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0); end
               K_MST_R:  begin e_we = 1'b1; e_waddr = 12'h300;
                               e_wdata = (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h8 : 32'h0); end
               K_JMP_T:  begin e_ia = 1'b1; e_iaddr = bus.mtvec_i & ~32'h3; guard_m = 1'b1; end
               default:  begin e_ia = 1'b1; e_iaddr = bus.mepc_i; guard_m = 1'b1; end
            endcase
         end else if (guard_m) begin
            guard_m = 1'b0;
         end else if (bus.inst_valid_i) begin
            sw = ms[3] & bus.mie_i[3] & bus.msip_i[0];
            tm = ms[3] & bus.mie_i[7] & bus.time_up_i;
            if (bus.ecall_i || bus.ebreak_i || (!bus.mret_i && (sw || tm))) begin
               push_step(K_MEPC, bus.inst_addr_i);
               push_step(K_MCAUSE, bus.ecall_i ? 32'd11 : bus.ebreak_i ? 32'd3 :
                                   sw ? 32'h8000_0003 : 32'h8000_0007);
               push_step(K_MST_T, 32'd0);
               push_step(K_JMP_T, 32'd0);
            end else if (bus.mret_i) begin
               push_step(K_MST_R, 32'd0);
               push_step(K_JMP_R, 32'd0);
            end
            e_hold = (sched.size() != 0);
         end
         check_eq("hold",        {31'd0, obs_hold}, {31'd0, e_hold});
         check_eq("csr_we",      {31'd0, obs_we},   {31'd0, e_we});
         check_eq("csr_waddr",   {20'd0, obs_waddr}, {20'd0, e_waddr});
         check_eq("csr_wdata",   obs_wdata, e_wdata);
         check_eq("int_assert",  {31'd0, obs_ia},   {31'd0, e_ia});
         check_eq("int_addr",    obs_iaddr, e_iaddr);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      bus.time_up_i = 1'b0;    bus.msip_i = 32'd0;   bus.inst_valid_i = 1'b0;
      bus.inst_addr_i = 32'd0; bus.ecall_i = 1'b0;   bus.ebreak_i = 1'b0;
      bus.mret_i = 1'b0;       bus.mstatus_i = 32'd0; bus.mie_i = 32'd0;
      bus.mtvec_i = 32'd0;     bus.mepc_i = 32'd0;
   endtask

   initial begin
      rst = 1'b1;
      quiet_inputs();
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_eq("rst_we", {31'd0, obs_we}, 32'd0);
      check_eq("rst_ia", {31'd0, obs_ia}, 32'd0);
      check_eq("rst_addr", obs_iaddr, 32'd0);

      // Timer interrupt
      bus.inst_valid_i = 1'b1; bus.mstatus_i = 32'h8; bus.mie_i = 32'h80;
      bus.mtvec_i = 32'h100;   bus.inst_addr_i = 32'h40; bus.time_up_i = 1'b1;
      tick(); check_eq("tmr_hold_n", {31'd0, obs_hold}, 32'd1);
      tick(); check_eq("tmr_mepc_a", {20'd0, obs_waddr}, 32'h341); check_eq("tmr_mepc_d", obs_wdata, 32'h40);
      tick(); check_eq("tmr_mcause", obs_wdata, 32'h8000_0007);
      tick(); check_eq("tmr_mstatus", obs_wdata, 32'h80);
      tick(); check_eq("tmr_jump", obs_iaddr, 32'h100); check_eq("tmr_hold_n4", {31'd0, obs_hold}, 32'd1);
      bus.time_up_i = 1'b0; bus.inst_valid_i = 1'b0;
      tick(); check_eq("tmr_hold_after", {31'd0, obs_hold}, 32'd0);

      // ecall with a pending software interrupt
      bus.inst_valid_i = 1'b1; bus.ecall_i = 1'b1; bus.msip_i = 32'd1;
      bus.mie_i = 32'h8; bus.mstatus_i = 32'h8; bus.inst_addr_i = 32'h20;
      tick();
      tick(); check_eq("ecall_mepc", obs_wdata, 32'h20);
      tick(); check_eq("ecall_mcause", obs_wdata, 32'd11);
      bus.ecall_i = 1'b0;
      tick();
      bus.mstatus_i = 32'h80;
      tick();
      for (int i = 0; i < 10; i++) begin
         tick(); check_eq("ecall_masked_hold", {31'd0, obs_hold}, 32'd0);
      end

      // mret
      bus.msip_i = 32'd0; bus.mret_i = 1'b1; bus.mepc_i = 32'h44;
      tick(); check_eq("mret_hold", {31'd0, obs_hold}, 32'd1);
      tick(); check_eq("mret_mstatus", obs_wdata, 32'h88);
      bus.mret_i = 1'b0;
      tick(); check_eq("mret_jump", obs_iaddr, 32'h44);
      bus.inst_valid_i = 1'b0;
      tick();

      // Masking by MIE and by mie[7]
      bus.inst_valid_i = 1'b1; bus.time_up_i = 1'b1; bus.mstatus_i = 32'h0; bus.mie_i = 32'h80;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) begin bus.mstatus_i = 32'h8; bus.mie_i = 32'h0; end
         tick();
         check_eq("mask_hold", {31'd0, obs_hold}, 32'd0);
         check_eq("mask_we", {31'd0, obs_we}, 32'd0);
      end

      // Software beats timer; guard suppresses detection right after the redirect
      bus.msip_i = 32'd1; bus.mie_i = 32'h88; bus.mstatus_i = 32'h8; bus.inst_addr_i = 32'h60;
      tick();
      tick();
      tick(); check_eq("prio_mcause", obs_wdata, 32'h8000_0003);
      tick();
      tick(); check_eq("prio_jump", {31'd0, obs_ia}, 32'd1);
      tick(); check_eq("guard_hold", {31'd0, obs_hold}, 32'd0);
      bus.inst_valid_i = 1'b0;
      tick();

      // Reset while in W_MCAUSE
      bus.inst_valid_i = 1'b1; bus.msip_i = 32'd0;
      tick();
      bus.inst_valid_i = 1'b0; bus.time_up_i = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("rst_mid_we", {31'd0, obs_we}, 32'd0);
         check_eq("rst_mid_ia", {31'd0, obs_ia}, 32'd0);
         check_eq("rst_mid_hold", {31'd0, obs_hold}, 32'd0);
      end

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         int r;
         r = $urandom_range(19, 0);
         bus.inst_valid_i = ($urandom_range(3, 0) != 0);
         bus.ecall_i      = (r == 0) || (r == 3);
         bus.ebreak_i     = (r == 1) || (r == 3);
         bus.mret_i       = (r == 2) || (r == 3) || (r == 4);
         bus.time_up_i    = $urandom_range(1, 0);
         bus.msip_i       = $urandom;
         bus.mstatus_i    = $urandom;
         bus.mie_i        = $urandom;
         bus.mtvec_i      = $urandom;
         bus.mepc_i       = $urandom;
         bus.inst_addr_i  = $urandom;
         rst              = ($urandom_range(149, 0) == 0);
         tick();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
